// File: rtl/vga_pkg.sv
// Shared definitions for the video output buffer writer.
//   - Default pixel width, FIFO depth and clocks per pixel period.
//   - Writer FSM state encoding.
package vga_pkg;

    localparam int BPP_DEF           = 6;
    localparam int DEPTH_DEF         = 16;
    localparam int CLK_PER_PIXEL_DEF = 4;

    typedef enum logic [1:0] {
        S_WAIT   = 2'd0,
        S_STROBE = 2'd1,
        S_HOLD   = 2'd2
    } state_t;

endpackage

// File: rtl/vbuffer_writer_fifo.sv
// Synchronous FIFO holding pixels between the renderer and the writer FSM.
// Ports:
//   i_clk, i_rst     clock, asynchronous active-high reset
//   i_wr_en/i_wr_data push request and pixel (ignored while full)
//   i_rd_req         pop request; loads o_rd_data with the head, or 0 if empty
//   o_rd_data        registered read data
//   o_full, o_empty  occupancy flags from the pointer registers
//   o_level          occupancy, 0..DEPTH
module vbuffer_writer_fifo
    import vga_pkg::*;
#(
    parameter int BPP   = BPP_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_wr_en,
    input  logic [BPP-1:0]           i_wr_data,
    input  logic                     i_rd_req,
    output logic [BPP-1:0]           o_rd_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_level
);

    localparam int AW = $clog2(DEPTH);

    // Pointers carry one extra wrap bit to tell full from empty.
    logic [AW:0]    r_wptr;
    logic [AW:0]    r_rptr;
    logic [BPP-1:0] r_mem [DEPTH];
    logic [BPP-1:0] r_rd_data;
    logic           w_full;
    logic           w_empty;
    logic           w_push;
    logic           w_pop;

    assign w_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_empty = (r_wptr == r_rptr);
    assign w_push  = i_wr_en && !w_full;
    assign w_pop   = i_rd_req && !w_empty;

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wptr[AW-1:0]] <= i_wr_data;
        end
    end

    // Emptiness is judged on registered pointers, so a pixel pushed on the
    // pop cycle is not seen by that pop.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_rd_data <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (i_rd_req) begin
                r_rd_data <= w_empty ? '0 : r_mem[r_rptr[AW-1:0]];
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
        end
    end

    assign o_rd_data = r_rd_data;
    assign o_full    = w_full;
    assign o_empty   = w_empty;
    assign o_level   = r_wptr - r_rptr;

endmodule

// File: rtl/vbuffer_writer.sv
// Pixel-write side of the video output buffer. Buffers renderer pixels and
// issues one ReqWrite pulse per unblanked pixel period; the receiver latches
// DataIn on the falling edge of ReqWrite. An empty FIFO at a pop writes 0 and
// sets the sticky Underrun flag.
// Ports:
//   Clk, Reset            clock (CLK_PER_PIXEL x pixel rate), async active-high reset
//   SrcData/SrcValid/SrcReady  renderer stream handshake
//   Blank                 blanking, suppresses pop and strobe at period start
//   ClrUnderrun           clears Underrun (a new underrun wins)
//   ReqWrite, DataIn      write strobe and zero-extended pixel to the receiver
//   Underrun, Level       sticky underrun flag and FIFO occupancy
module vbuffer_writer
    import vga_pkg::*;
#(
    parameter int BPP           = BPP_DEF,
    parameter int DEPTH         = DEPTH_DEF,
    parameter int CLK_PER_PIXEL = CLK_PER_PIXEL_DEF
) (
    input  logic                   Clk,
    input  logic                   Reset,
    input  logic [BPP-1:0]         SrcData,
    input  logic                   SrcValid,
    output logic                   SrcReady,
    input  logic                   Blank,
    input  logic                   ClrUnderrun,
    output logic                   ReqWrite,
    output logic [7:0]             DataIn,
    output logic                   Underrun,
    output logic [$clog2(DEPTH):0] Level
);

    localparam int            PW         = $clog2(CLK_PER_PIXEL);
    localparam logic [PW-1:0] PHASE_LAST = PW'(CLK_PER_PIXEL - 1);

    logic [PW-1:0]  r_phase;
    state_t         r_state;
    state_t         w_state_next;
    logic           r_underrun;
    logic           w_pop_req;
    logic           w_req_write;
    logic           w_fifo_full;
    logic           w_fifo_empty;
    logic [BPP-1:0] w_rd_data;

    vbuffer_writer_fifo #(
        .BPP   (BPP),
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk     (Clk),
        .i_rst     (Reset),
        .i_wr_en   (SrcValid),
        .i_wr_data (SrcData),
        .i_rd_req  (w_pop_req),
        .o_rd_data (w_rd_data),
        .o_full    (w_fifo_full),
        .o_empty   (w_fifo_empty),
        .o_level   (Level)
    );

    // Free-running pixel-period phase.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_phase <= '0;
        end else if (r_phase == PHASE_LAST) begin
            r_phase <= '0;
        end else begin
            r_phase <= r_phase + 1'b1;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state <= S_WAIT;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ReqWrite decodes straight from the state register so reset drops it
    // without waiting for a clock edge.
    always_comb begin
        w_state_next = r_state;
        w_pop_req    = 1'b0;
        w_req_write  = 1'b0;
        case (r_state)
            S_WAIT: begin
                if ((r_phase == '0) && !Blank) begin
                    w_pop_req    = 1'b1;
                    w_state_next = S_STROBE;
                end
            end
            S_STROBE: begin
                w_req_write  = 1'b1;
                w_state_next = S_HOLD;
            end
            S_HOLD: begin
                if (r_phase == PHASE_LAST) begin
                    w_state_next = S_WAIT;
                end
            end
            default: begin
                w_state_next = S_WAIT;
            end
        endcase
    end

    // A fresh underrun outranks a same-cycle clear.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_underrun <= 1'b0;
        end else if (w_pop_req && w_fifo_empty) begin
            r_underrun <= 1'b1;
        end else if (ClrUnderrun) begin
            r_underrun <= 1'b0;
        end
    end

    // Pixel occupies the low BPP bits of the receiver byte; the rest are 0.
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_data
            if (gi < BPP) begin : g_px
                assign DataIn[gi] = w_rd_data[gi];
            end else begin : g_pad
                assign DataIn[gi] = 1'b0;
            end
        end
    endgenerate

    assign SrcReady = !w_fifo_full;
    assign ReqWrite = w_req_write;
    assign Underrun = r_underrun;

endmodule
